// File: rtl/vga_scan_gen.sv
// 640x480@60 raster timing generator: pixel prescaler, h/v counters, syncs, video gate, frame pulse/counter.
// Latency: all outputs registered; hsync/vsync/video_on come from next-state counters, so they have zero skew to scan_x/scan_y.
// Backpressure: none; free-running, outputs never stall.
module vga_scan_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] scan_x,
    output logic [8:0] scan_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX    = DW'(CLK_DIV - 1);
    localparam logic [9:0]    H_TOTAL_M1 = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]    V_TOTAL_M1 = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]    H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0]    V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]    VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]    h_count_q, h_count_d;
    logic [9:0]    v_count_q, v_count_d;
    logic [7:0]    frame_count_q, frame_count_d;
    logic          pixel_tick_q, pixel_tick_d;
    logic          frame_start_q, frame_start_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_on_q, video_on_d;

    // Next-state: prescaler, raster advance on the tick cycle, and outputs decoded from the next counters.
    always_comb begin
        div_cnt_d     = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + DW'(1);
        h_count_d     = h_count_q;
        v_count_d     = v_count_q;
        frame_count_d = frame_count_q;
        frame_start_d = 1'b0;
        // pixel_tick_q is high exactly while div_cnt_q == DIV_MAX, so it doubles as the advance enable.
        if (pixel_tick_q) begin
            if (h_count_q == H_TOTAL_M1) begin
                h_count_d = '0;
                if (v_count_q == V_TOTAL_M1) begin
                    v_count_d     = '0;
                    frame_count_d = frame_count_q + 8'd1;
                    frame_start_d = 1'b1;
                end else begin
                    v_count_d = v_count_q + 10'd1;
                end
            end else begin
                h_count_d = h_count_q + 10'd1;
            end
        end
        pixel_tick_d = (div_cnt_d == DIV_MAX);
        hsync_d      = !((h_count_d >= HS_FIRST) && (h_count_d <= HS_LAST));
        vsync_d      = !((v_count_d >= VS_FIRST) && (v_count_d <= VS_LAST));
        video_on_d   = (h_count_d < H_VIS) && (v_count_d < V_VIS);
    end

    // State register with synchronous reset to the (0,0) idle raster.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q     <= '0;
            h_count_q     <= '0;
            v_count_q     <= '0;
            frame_count_q <= '0;
            pixel_tick_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b1;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            frame_count_q <= frame_count_d;
            pixel_tick_q  <= pixel_tick_d;
            frame_start_q <= frame_start_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
        end
    end

    assign scan_x      = h_count_q;
    assign scan_y      = v_count_q[8:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_tick  = pixel_tick_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: full-size instance for line timing, tiny-raster instance for frame/vsync/wrap.
// Latency: outputs sampled on the falling edge; every clock compared against a closed-form raster model.
// Backpressure: none; stimulus is reset only.
module tb_vga_scan_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    logic [9:0] x_a, x_b;
    logic [8:0] y_a, y_b;
    logic       hs_a, hs_b, vs_a, vs_b, vo_a, vo_b, pt_a, pt_b, fs_a, fs_b;
    logic [7:0] fc_a, fc_b;

    vga_scan_gen u_a (
        .clk(clk), .reset(rst_a), .scan_x(x_a), .scan_y(y_a), .hsync(hs_a), .vsync(vs_a),
        .video_on(vo_a), .pixel_tick(pt_a), .frame_start(fs_a), .frame_count(fc_a)
    );

    vga_scan_gen #(
        .CLK_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_b (
        .clk(clk), .reset(rst_b), .scan_x(x_b), .scan_y(y_b), .hsync(hs_b), .vsync(vs_b),
        .video_on(vo_b), .pixel_tick(pt_b), .frame_start(fs_b), .frame_count(fc_b)
    );

    wire logic [31:0] vec_a = {x_a, y_a, hs_a, vs_a, vo_a, pt_a, fs_a, fc_a};
    wire logic [31:0] vec_b = {x_b, y_b, hs_b, vs_b, vo_b, pt_b, fs_b, fc_b};
    localparam logic [31:0] RST_VEC = {10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

    int n_checks = 0;
    int n_fail   = 0;
    int n_a = 0;
    int n_b = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Closed-form raster: n = clock edges since the last reset edge.
    function automatic logic [31:0] exp_vec(input int n, input int cd, input int ha, input int hf,
                                            input int hs, input int hb, input int va, input int vf,
                                            input int vs, input int vb);
        int ht, vt, p, h, v, f;
        logic pt, fs, hsn, vsn, von;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        p   = n / cd;
        h   = p % ht;
        v   = (p / ht) % vt;
        f   = (p / (ht * vt)) % 256;
        pt  = (n % cd) == cd - 1;
        fs  = ((n % cd) == 0) && (p > 0) && ((p % (ht * vt)) == 0);
        hsn = !((h >= ha + hf) && (h < ha + hf + hs));
        vsn = !((v >= va + vf) && (v < va + vf + vs));
        von = (h < ha) && (v < va);
        return {10'(h), 9'(v), hsn, vsn, von, pt, fs, 8'(f)};
    endfunction

    // Edge counters for the model, restarted by each sampled reset.
    always @(posedge clk) begin
        n_a <= rst_a ? 0 : n_a + 1;
        n_b <= rst_b ? 0 : n_b + 1;
    end

    // Every-clock comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("A_model", vec_a, exp_vec(n_a, 4, 640, 16, 96, 48, 480, 10, 2, 33));
            chk("B_model", vec_b, exp_vec(n_b, 2, 4, 1, 2, 1, 2, 1, 1, 1));
        end
    end

    int   cnt, fsi;
    bit   found;
    logic [9:0] prev_x;
    logic       prev_vo;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("A_reset_vec", vec_a, RST_VEC);
        chk("B_reset_vec", vec_b, RST_VEC);
        rst_a = 1'b0;

        cnt = 0; found = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(negedge clk);
            if (pt_a) begin found = 1; cnt = i; end
        end
        chk("A_first_tick_clks", cnt, 3);
        cnt = 0; found = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(negedge clk);
            if (pt_a) begin found = 1; cnt = i; end
        end
        chk("A_tick_period", cnt, 4);
        chk("A_x_step", x_a, 1);

        found = 0; prev_x = 0; prev_vo = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            prev_x = x_a; prev_vo = vo_a;
            @(negedge clk);
            if (x_a == 10'd640) found = 1;
        end
        chk("A_x640_seen", found, 1);
        chk("A_vo_before_640", {prev_x, prev_vo}, {10'd639, 1'b1});
        chk("A_vo_at_640", vo_a, 0);
        chk("A_hs_at_640", hs_a, 1);

        cnt = 0; found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (!hs_a) cnt++;
            if (x_a == 10'd0) found = 1;
        end
        chk("A_wrap_seen", found, 1);
        chk("A_hsync_clks", cnt, 384);
        chk("A_wrap_y1", y_a, 1);

        cnt = 0; found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            prev_x = x_a;
            @(negedge clk);
            cnt++;
            if (x_a == 10'd0 && prev_x == 10'd799) found = 1;
        end
        chk("A_line_clks", cnt, 3200);
        chk("A_wrap_y2", y_a, 2);

        found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (x_a == 10'd700) found = 1;
        end
        chk("A_x700_seen", found, 1);
        chk("A_hs_low_700", hs_a, 0);
        rst_a = 1'b1;
        @(negedge clk);
        chk("A_midline_reset", vec_a, RST_VEC);
        rst_a = 1'b0;
        repeat (100) @(negedge clk);
        chk("A_restart_x", x_a, 25);
        chk("B_held_reset", vec_b, RST_VEC);

        rst_b = 1'b0;
        cnt = 0; fsi = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (!vs_b) cnt++;
            if (fs_b && fsi == 0) fsi = i;
        end
        chk("B_vsync_clks", cnt, 16);
        chk("B_first_fs_clk", fsi, 80);
        chk("B_fc1", fc_b, 1);

        cnt = 0; found = 0;
        for (int i = 1; i <= 200 && !found; i++) begin
            @(negedge clk);
            if (fs_b) begin found = 1; cnt = i; end
        end
        chk("B_frame_period", cnt, 80);
        chk("B_fc2", fc_b, 2);

        found = 0;
        for (int i = 0; i < 25000 && !found; i++) begin
            @(negedge clk);
            if (fc_b == 8'd255) found = 1;
        end
        chk("B_fc255_seen", found, 1);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (fs_b) found = 1;
        end
        chk("B_fs_after_255", found, 1);
        chk("B_fc_wrap", fc_b, 0);

        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (x_b == 10'd5 && y_b == 9'd3) found = 1;
        end
        chk("B_h5v3_seen", found, 1);
        chk("B_syncs_low", {hs_b, vs_b}, 2'b00);
        rst_b = 1'b1;
        @(negedge clk);
        chk("B_midsync_reset", vec_b, RST_VEC);
        rst_b = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
